register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5: register count = 2**REG_ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_READ, default 3: number of read ports, legal range 1..4.
REQ-004 SHALL have port i_Clock, input, 1: single clock, all state updated on rising edge.
REQ-005 SHALL have port i_Reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_Enable, input, 1: global enable for writes, issues and read outputs.
REQ-007 SHALL have port i_Read_Addr, input, NUM_READ*REG_ADDR_WIDTH: packed read addresses, port k in slice k.
REQ-008 SHALL have port o_Read_Data, output, NUM_READ*XLEN: packed read data, port k in slice k.
REQ-009 SHALL have port o_Read_Busy, output, NUM_READ: port k's register has a pending write.
REQ-010 SHALL have ports i_Write_Enable_0/1, input, 1 each: write-port strobes.
REQ-011 SHALL have ports i_Write_Addr_0/1, input, REG_ADDR_WIDTH each: write-port addresses.
REQ-012 SHALL have ports i_Write_Data_0/1, input, XLEN each: write-port data.
REQ-013 SHALL have port i_Issue_Valid, input, 1: mark a destination register as pending.
REQ-014 SHALL have port i_Issue_Addr, input, REG_ADDR_WIDTH: destination being issued.
REQ-015 SHALL have port i_Flush, input, 1: clear all pending marks.
REQ-016 SHALL have port o_Busy_Count, output, REG_ADDR_WIDTH+1: number of registers currently pending.

Function
REQ-017 SHALL keep register 0 reading as 0 and never pending; writes and issues to address 0 are ignored.
REQ-018 SHALL perform writes with i_Enable=1, a port's write enable=1 and a nonzero address, taking effect at the next rising edge.
REQ-019 SHALL let port 1 win when both write ports target the same nonzero address in one cycle.
REQ-020 SHALL read combinationally, with zero-cycle bypass: a read address matching an active write returns that write's data, port 1 winning over port 0.
REQ-021 SHALL drive all read data and all o_Read_Busy bits to 0 while i_Enable=0.
REQ-022 SHALL hold one pending bit per register, driving o_Read_Busy[k] from the registered pending bit of read port k's address, with no bypass.
REQ-023 SHALL set the pending bit of i_Issue_Addr at the edge when i_Enable and i_Issue_Valid are both 1.
REQ-024 SHALL clear a register's pending bit at the edge on which that register is written by either port.
REQ-025 SHALL leave the pending bit set when an issue and a write hit the same address in one cycle (issue wins).
REQ-026 SHALL make i_Flush clear all pending bits at the edge, overriding a same-cycle issue; register writes still occur.
REQ-027 SHALL update o_Busy_Count registered, equal to the population of pending bits after each edge; range 0..2**REG_ADDR_WIDTH-1.
REQ-028 SHALL treat a write to a non-pending register as a normal write, leaving the count unchanged.
REQ-029 SHALL hold all state when i_Enable=0, including i_Flush, which is ignored.

Reset
REQ-030 SHALL, while i_Reset is high, asynchronously clear all registers, all pending bits and o_Busy_Count to 0.
REQ-031 SHALL give reset priority over any simultaneous write, issue or flush; state is zero on the first edge after deassertion.

Verification
REQ-032 SHALL be verified by dual write collision: W0(x5,0x11), W1(x5,0x22) same cycle -> read x5 = 0x22 in that cycle (bypass) and afterward.
REQ-033 SHALL be verified by x0 protection: W0(x0,0xFFFF_FFFF) and issue x0 -> read x0 = 0, o_Busy_Count = 0.
REQ-034 SHALL be verified by scoreboard: issue x3, x7 on consecutive cycles -> count 2, o_Read_Busy for x3 = 1; W1(x3,0xAB) -> count 1, x3 reads 0xAB, not busy.
REQ-035 SHALL be verified by issue/write collision: x9 pending, issue x9 and W0(x9,0x5) same cycle -> x9 = 0x5, still busy, count unchanged.
REQ-036 SHALL be verified by flush: 4 registers pending, i_Flush plus issue x2 -> count 0, all busy bits 0.
REQ-037 SHALL be verified by mid-operation reset: registers written and pending, i_Reset pulsed asynchronously between edges -> all reads 0 and count 0 immediately.

Source files
------------

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
// Multi-read, dual-write register file with a per-register pending
// scoreboard. Register 0 always reads as zero and can never be pending.
//
// Parameters
//   XLEN            data width
//   REG_ADDR_WIDTH  address width; 2**REG_ADDR_WIDTH registers
//   NUM_READ        number of read ports (1..4)
//
// Ports
//   i_Clock          rising-edge clock
//   i_Reset          asynchronous active-high reset
//   i_Enable         global enable for writes, issues, flush and read outputs
//   i_Read_Addr      packed read addresses, port k in slice k
//   o_Read_Data      packed read data (write-through bypass), port k in slice k
//   o_Read_Busy      registered pending bit of each read port's register
//   i_Write_*_0/1    two write ports; port 1 wins on an address collision
//   i_Issue_Valid    mark i_Issue_Addr pending
//   i_Issue_Addr     destination register being issued
//   i_Flush          clear every pending bit
//   o_Busy_Count     registered number of pending registers
// ---------------------------------------------------------------------------
module register_file_mp #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_READ       = 3
) (
    input  logic                               i_Clock,
    input  logic                               i_Reset,
    input  logic                               i_Enable,
    input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] i_Read_Addr,
    output logic [NUM_READ*XLEN-1:0]           o_Read_Data,
    output logic [NUM_READ-1:0]                o_Read_Busy,
    input  logic                               i_Write_Enable_0,
    input  logic [REG_ADDR_WIDTH-1:0]          i_Write_Addr_0,
    input  logic [XLEN-1:0]                    i_Write_Data_0,
    input  logic                               i_Write_Enable_1,
    input  logic [REG_ADDR_WIDTH-1:0]          i_Write_Addr_1,
    input  logic [XLEN-1:0]                    i_Write_Data_1,
    input  logic                               i_Issue_Valid,
    input  logic [REG_ADDR_WIDTH-1:0]          i_Issue_Addr,
    input  logic                               i_Flush,
    output logic [REG_ADDR_WIDTH:0]            o_Busy_Count
);

    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic [XLEN-1:0]         regs_q [NREG];
    logic [XLEN-1:0]         regs_d [NREG];
    logic [NREG-1:0]         pend_q;
    logic [NREG-1:0]         pend_d;
    logic [REG_ADDR_WIDTH:0] count_q;
    logic [REG_ADDR_WIDTH:0] count_d;

    logic wr0_act;
    logic wr1_act;
    logic iss_act;

    // Writes to x0 are dropped here so neither storage nor bypass sees them.
    assign wr0_act = i_Enable && i_Write_Enable_0 && (i_Write_Addr_0 != '0);
    assign wr1_act = i_Enable && i_Write_Enable_1 && (i_Write_Addr_1 != '0);
    assign iss_act = i_Enable && i_Issue_Valid && (i_Issue_Addr != '0);

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;

        // Port 1 is applied last so it wins a same-address collision.
        if (wr0_act) begin
            regs_d[i_Write_Addr_0] = i_Write_Data_0;
            pend_d[i_Write_Addr_0] = 1'b0;
        end
        if (wr1_act) begin
            regs_d[i_Write_Addr_1] = i_Write_Data_1;
            pend_d[i_Write_Addr_1] = 1'b0;
        end

        // Issue is applied after the write clears, so a same-cycle issue
        // keeps the register pending; flush overrides both.
        if (iss_act) begin
            pend_d[i_Issue_Addr] = 1'b1;
        end
        if (i_Enable && i_Flush) begin
            pend_d = '0;
        end
        pend_d[0] = 1'b0;

        count_d = '0;
        for (int i = 0; i < NREG; i++) begin
            count_d = count_d + {{REG_ADDR_WIDTH{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    assign o_Busy_Count = count_q;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [REG_ADDR_WIDTH-1:0] raddr;
        logic [XLEN-1:0]           rdata;

        assign raddr = i_Read_Addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

        always_comb begin
            rdata = regs_q[raddr];
            if (wr0_act && (i_Write_Addr_0 == raddr)) begin
                rdata = i_Write_Data_0;
            end
            if (wr1_act && (i_Write_Addr_1 == raddr)) begin
                rdata = i_Write_Data_1;
            end
            if (!i_Enable || (raddr == '0)) begin
                rdata = '0;
            end
        end

        assign o_Read_Data[k*XLEN +: XLEN] = rdata;
        // Busy reflects the registered scoreboard only; no bypass.
        assign o_Read_Busy[k] = i_Enable && pend_q[raddr];
    end

endmodule
